instr_fetch_responder: RTL
==========================

// Module: instr_fetch_responder
// PURPOSE
//  Memory-side responder for the instruction-queue fetch handshake (instr_read / instr_mem_address ->
//  instr_mem_resp / in). Holds one cache line in a line buffer; a hit answers in 1 cycle.
//  A miss issues a LINE_BEATS-beat burst read to physical memory, fills the buffer, then answers.
//  Sits between the instruction queue's fetch port and the physical-memory arbiter.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  BEAT_W      64  physical-memory data beat width (multiple of 32)
//  LINE_BEATS  4   beats per line; line = LINE_BEATS*BEAT_W/8 bytes (32 B default)
// PORTS
//  clk                input   1       clock, all state on posedge
//  reset_n            input   1       synchronous, active-low reset
//  instr_read         input   1       fetch request; held high until instr_mem_resp
//  instr_mem_address  input   ADDR_W  fetch byte address; stable while instr_read; bits[1:0] ignored
//  instr_mem_resp     output  1       one-cycle pulse: in is valid this cycle
//  in                 output  32      fetched instruction word
//  flush              input   1       invalidate line buffer (fence.i / memory rewrite)
//  pmem_read          output  1       burst read request to physical memory
//  pmem_address       output  ADDR_W  line-aligned burst address (low log2(line bytes) bits = 0)
//  pmem_rdata         input   BEAT_W  burst beat data
//  pmem_resp          input   1       beat valid; LINE_BEATS consecutive-or-gapped pulses per burst
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, line_valid=0, beat_cnt=0, tag=0; outputs
//   instr_mem_resp=0, in=32'h0, pmem_read=0, pmem_address=0. Reset mid-FILL abandons burst.
//  State: line buffer (LINE_BEATS*BEAT_W bits), tag = addr[ADDR_W-1:log2(line bytes)], line_valid,
//   req_addr (latched on acceptance), beat_cnt ($clog2(LINE_BEATS) bits), drop flag.
//  FSM:
//   IDLE: instr_read=1 -> latch req_addr; hit (line_valid && tag==addr tag && !flush) -> RESP;
//         otherwise -> FILL. instr_read=0 -> stay.
//   FILL: pmem_read=1, pmem_address={req tag, zeros}. Each pmem_resp writes pmem_rdata into beat
//         beat_cnt, beat_cnt++. On beat LINE_BEATS-1: tag<=req tag, line_valid<=!drop, drop<=0,
//         beat_cnt<=0 -> RESP. pmem_read drops in RESP (one cycle after last beat).
//   RESP: instr_mem_resp=1, in=word req_addr[log2(line bytes)-1:2] of buffer -> IDLE.
//  Latency: hit = resp 1 cycle after request seen in IDLE; miss = resp 1 cycle after last beat.
//  Back-to-back: IDLE in the cycle after RESP evaluates a fresh request (requester advances on resp).
//  Word select: beat = word_idx / (BEAT_W/32), lane = word_idx % (BEAT_W/32); little-endian lanes.
//  in holds last returned word outside RESP (don't-care to consumers; bench checks only at resp).
//  flush: IDLE/RESP -> line_valid<=0 next cycle; flush same cycle as a would-be hit forces miss.
//   FILL -> drop<=1; burst completes, response still delivered from buffer, line left invalid.
//   flush and reset together: reset wins.
//  instr_read dropped before resp (protocol violation): in-flight fill completes; resp still pulses.
//  pmem_resp outside FILL ignored. Address compare uses full tag; no wrap-around special case
//   (top line 0xFFFFFFE0 handled like any other).
// TESTING
//  1 Reset then read @0x0000_0040 -> pmem_read, pmem_address=0x40; 4 beats (beat0=64'h00000013_00000093..)
//    -> resp 1 cycle after beat3, in=32'h00000093; pmem_read low in resp cycle.
//  2 After 1, read @0x44 then @0x5C -> each resp 1 cycle after request, in = word1 / word7 of line,
//    no pmem_read.
//  3 Read @0x60 (miss, other line) -> new burst at 0x60; subsequent read @0x40 misses again.
//  4 flush asserted during beat2 of a fill for 0x80 -> resp with correct word; next read @0x84
//    refills (pmem_read=1, address 0x80).
//  5 Gapped pmem_resp (idle cycles between beats) -> identical data, resp after final beat only.
//  6 reset_n low mid-FILL (after beat1) -> next cycle all outputs 0, IDLE; read @0x40 refetches
//    full line from beat0.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder
// Memory-side responder for the instruction fetch handshake. It keeps one cache
// line in a line buffer. A hit is answered from that buffer. A miss runs a
// LINE_BEATS-beat burst read from physical memory, fills the buffer and then
// answers. All outputs come straight from registers.
module instr_fetch_responder #(
  parameter int ADDR_W     = 32,
  parameter int BEAT_W     = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_read,
  input  logic [ADDR_W-1:0] instr_mem_address,
  output logic              instr_mem_resp,
  output logic [31:0]       in,
  input  logic              flush,
  output logic              pmem_read,
  output logic [ADDR_W-1:0] pmem_address,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int LINE_W = LINE_BEATS * BEAT_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int WI_W   = OFF_W - 2;
  localparam int BC_W   = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(LINE_BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The line is packed so that 32-bit word w sits at bits [w*32 +: 32].
  // Beats are little-endian, so word index = beat*(BEAT_W/32) + lane.
  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [WI_W-1:0]   idx);
    return line[{idx, 5'b00000} +: 32];
  endfunction

  logic [1:0]        state_r;
  logic [LINE_W-1:0] line_r;
  logic [LINE_W-1:0] line_next_s;
  logic [TAG_W-1:0]  tag_r;
  logic              line_valid_r;
  logic [TAG_W-1:0]  req_tag_r;
  logic [WI_W-1:0]   req_word_r;
  logic [BC_W-1:0]   beat_cnt_r;
  logic              drop_r;

  logic [TAG_W-1:0]  addr_tag_s;
  logic [WI_W-1:0]   addr_word_s;
  logic              hit_s;
  logic              fill_beat_s;
  logic              last_beat_s;
  logic              unused_addr_bits_s;

  assign addr_tag_s         = instr_mem_address[ADDR_W-1:OFF_W];
  assign addr_word_s        = instr_mem_address[OFF_W-1:2];
  assign unused_addr_bits_s = ^instr_mem_address[1:0];
  // A flush in the same cycle as a would-be hit forces a miss.
  assign hit_s       = line_valid_r && (tag_r == addr_tag_s) && !flush;
  assign fill_beat_s = (state_r == ST_FILL) && pmem_resp;
  assign last_beat_s = fill_beat_s && (beat_cnt_r == LAST_BEAT);

  // Merge the incoming beat into a copy of the line, so the last beat can be returned in the same edge
  always_comb begin
    line_next_s = line_r;
    for (int b = 0; b < LINE_BEATS; b++) begin
      if (fill_beat_s && (beat_cnt_r == BC_W'(b))) begin
        line_next_s[b*BEAT_W +: BEAT_W] = pmem_rdata;
      end else begin
        line_next_s[b*BEAT_W +: BEAT_W] = line_r[b*BEAT_W +: BEAT_W];
      end
    end
  end

  // Fetch FSM, line buffer state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      line_r         <= '0;
      tag_r          <= '0;
      line_valid_r   <= 1'b0;
      req_tag_r      <= '0;
      req_word_r     <= '0;
      beat_cnt_r     <= '0;
      drop_r         <= 1'b0;
      instr_mem_resp <= 1'b0;
      in             <= 32'h0000_0000;
      pmem_read      <= 1'b0;
      pmem_address   <= '0;
    end else begin
      line_r <= line_next_s;
      case (state_r)
        ST_IDLE: begin
          instr_mem_resp <= 1'b0;
          if (flush) begin
            line_valid_r <= 1'b0;
          end
          if (instr_read) begin
            req_tag_r  <= addr_tag_s;
            req_word_r <= addr_word_s;
            if (hit_s) begin
              state_r        <= ST_RESP;
              instr_mem_resp <= 1'b1;
              in             <= sel_word(line_r, addr_word_s);
            end else begin
              state_r      <= ST_FILL;
              pmem_read    <= 1'b1;
              pmem_address <= {addr_tag_s, {OFF_W{1'b0}}};
              beat_cnt_r   <= '0;
            end
          end
        end
        ST_FILL: begin
          // A flush during the burst lets it finish but leaves the line invalid.
          if (flush) begin
            drop_r <= 1'b1;
          end
          if (last_beat_s) begin
            tag_r          <= req_tag_r;
            line_valid_r   <= !(drop_r || flush);
            drop_r         <= 1'b0;
            beat_cnt_r     <= '0;
            state_r        <= ST_RESP;
            pmem_read      <= 1'b0;
            instr_mem_resp <= 1'b1;
            in             <= sel_word(line_next_s, req_word_r);
          end else if (fill_beat_s) begin
            beat_cnt_r <= beat_cnt_r + BC_W'(1);
          end
        end
        ST_RESP: begin
          instr_mem_resp <= 1'b0;
          state_r        <= ST_IDLE;
          if (flush) begin
            line_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          line_valid_r   <= 1'b0;
          drop_r         <= 1'b0;
          beat_cnt_r     <= '0;
          instr_mem_resp <= 1'b0;
          pmem_read      <= 1'b0;
        end
      endcase
    end
  end

endmodule
